// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the two-master Wishbone B4 classic arbiter:
// arbiter state encoding, master index constants and default bus widths.
// ---------------------------------------------------------------------------
package wb_pkg;

   localparam int unsigned WB_ADDR_W = 32;
   localparam int unsigned WB_DATA_W = 32;

   // Master indices, also the encoding of the registered "last granted" bit
   localparam logic WB_M0 = 1'b0;
   localparam logic WB_M1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OWN_M0 = 2'd1,
      OWN_M1 = 2'd2
   } arb_state_t;

   // Ownership state corresponding to a master index
   function automatic arb_state_t own_state(input logic m);
      return (m == WB_M1) ? OWN_M1 : OWN_M0;
   endfunction

endpackage

// File: rtl/wb_watchdog.sv
// ---------------------------------------------------------------------------
// wb_watchdog
// Counts consecutive cycles of an unanswered strobe and flags expiry for one
// cycle when the run reaches TIMEOUT (the flagged cycle is the TIMEOUT-th).
// TIMEOUT = 0 disables expiry entirely.
// Ports:
//   clk_i, rst_n_i : clock, async active-low reset
//   i_en           : strobe high with no ack/err this cycle
//   i_clr          : grant released/changing, restart the count
//   o_expire_c     : combinational one-cycle expiry flag
// ---------------------------------------------------------------------------
module wb_watchdog #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic i_en,
   input  logic i_clr,
   output logic o_expire_c
);

   localparam int unsigned CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam int unsigned LAST_CNT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam bit          WD_ON    = (TIMEOUT != 0);

   logic [CNT_W-1:0] r_cnt;

   // r_cnt holds the unanswered cycles already elapsed, so the current cycle
   // is number r_cnt+1 of the run
   assign o_expire_c = WD_ON && i_en && (r_cnt == CNT_W'(LAST_CNT));

   // Run-length counter; restarts on any response, idle strobe, clear or expiry
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cnt <= '0;
      end else if (!WD_ON || i_clr || !i_en || o_expire_c) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/wb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// wb_bus_arbiter
// Round-robin arbiter sharing one Wishbone B4 classic slave port between the
// instruction-fetch master (M0) and the data master (M1). The grant is held
// for a whole CYC; slave-side signals and returns are zero-latency muxes of
// the owner. A watchdog forces an error on slaves that never answer.
// Ports:
//   clk_i, rst_n_i          : clock, async active-low reset
//   m0_* / m1_*             : master-side Wishbone ports (cyc/stb/we/addr/
//                             dat/sel in, dat/ack/err out)
//   wbs_*_o                 : slave-side request (cyc/stb/we/addr/dat/sel)
//   wbs_dat_i/ack_i/err_i   : slave response
// ---------------------------------------------------------------------------
module wb_bus_arbiter
   import wb_pkg::*;
#(
   parameter  int unsigned ADDR_W  = WB_ADDR_W,
   parameter  int unsigned DATA_W  = WB_DATA_W,
   parameter  int unsigned TIMEOUT = 255,
   localparam int unsigned SEL_W   = DATA_W / 8
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   // M0 (instruction fetch)
   input  logic              m0_cyc_i,
   input  logic              m0_stb_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_dat_i,
   input  logic [SEL_W-1:0]  m0_sel_i,
   output logic [DATA_W-1:0] m0_dat_o,
   output logic              m0_ack_o,
   output logic              m0_err_o,
   // M1 (data)
   input  logic              m1_cyc_i,
   input  logic              m1_stb_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_dat_i,
   input  logic [SEL_W-1:0]  m1_sel_i,
   output logic [DATA_W-1:0] m1_dat_o,
   output logic              m1_ack_o,
   output logic              m1_err_o,
   // Slave
   output logic              wbs_cyc_o,
   output logic              wbs_stb_o,
   output logic              wbs_we_o,
   output logic [ADDR_W-1:0] wbs_addr_o,
   output logic [DATA_W-1:0] wbs_dat_o,
   output logic [SEL_W-1:0]  wbs_sel_o,
   input  logic [DATA_W-1:0] wbs_dat_i,
   input  logic              wbs_ack_i,
   input  logic              wbs_err_i
);

   arb_state_t r_state;
   logic       r_last;

   logic w_release;
   logic w_stb;
   logic w_expire;

   // Current owner has dropped CYC: the grant is up for arbitration this edge
   assign w_release = ((r_state == OWN_M0) && !m0_cyc_i) ||
                      ((r_state == OWN_M1) && !m1_cyc_i);

   // Grant FSM: ties go to the master that was not granted last
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= IDLE;
         r_last  <= WB_M0;
      end else if ((r_state == IDLE) || w_release) begin
         if (m0_cyc_i && m1_cyc_i) begin
            r_state <= own_state(~r_last);
            r_last  <= ~r_last;
         end else if (m0_cyc_i) begin
            r_state <= OWN_M0;
            r_last  <= WB_M0;
         end else if (m1_cyc_i) begin
            r_state <= OWN_M1;
            r_last  <= WB_M1;
         end else begin
            r_state <= IDLE;
         end
      end
   end

   // Slave-side request mux; strobe kept raw here so the watchdog sees it
   always_comb begin
      wbs_cyc_o  = 1'b0;
      w_stb      = 1'b0;
      wbs_we_o   = 1'b0;
      wbs_addr_o = '0;
      wbs_dat_o  = '0;
      wbs_sel_o  = '0;
      case (r_state)
         OWN_M0: begin
            wbs_cyc_o  = m0_cyc_i;
            w_stb      = m0_stb_i;
            wbs_we_o   = m0_we_i;
            wbs_addr_o = m0_addr_i;
            wbs_dat_o  = m0_dat_i;
            wbs_sel_o  = m0_sel_i;
         end
         OWN_M1: begin
            wbs_cyc_o  = m1_cyc_i;
            w_stb      = m1_stb_i;
            wbs_we_o   = m1_we_i;
            wbs_addr_o = m1_addr_i;
            wbs_dat_o  = m1_dat_i;
            wbs_sel_o  = m1_sel_i;
         end
         default: ;
      endcase
   end

   wb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .i_en       (w_stb & ~(wbs_ack_i | wbs_err_i)),
      .i_clr      (w_release),
      .o_expire_c (w_expire)
   );

   // Expiry withdraws the strobe so the slave sees the access terminated
   assign wbs_stb_o = w_stb & ~w_expire;

   // Responses go only to the owner; ack and err pass through independently
   always_comb begin
      m0_dat_o = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      case (r_state)
         OWN_M0: begin
            m0_dat_o = wbs_dat_i;
            m0_ack_o = wbs_ack_i;
            m0_err_o = wbs_err_i | w_expire;
         end
         OWN_M1: begin
            m1_dat_o = wbs_dat_i;
            m1_ack_o = wbs_ack_i;
            m1_err_o = wbs_err_i | w_expire;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_bus_arbiter
// Directed scenarios followed by random traffic, every cycle compared with a
// behavioural model (owner index, last grant, unanswered-strobe run length).
// A second instance with TIMEOUT=0 shares the inputs to show the watchdog off.
// ---------------------------------------------------------------------------
module tb_wb_bus_arbiter;

   localparam int unsigned TO = 8;
   localparam logic [31:0] A0 = 32'h0000_0200;
   localparam logic [31:0] A1 = 32'h0000_0300;

   logic        clk;
   logic        rst_n;
   logic        m_cyc  [2];
   logic        m_stb  [2];
   logic        m_we   [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_dat  [2];
   logic [3:0]  m_sel  [2];
   logic [31:0] s_dat;
   logic        s_ack;
   logic        s_err;

   logic [31:0] m0_dat_o, m1_dat_o, wbs_addr_o, wbs_dat_o;
   logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic        wbs_cyc_o, wbs_stb_o, wbs_we_o;
   logic [3:0]  wbs_sel_o;

   logic [31:0] z_m0_dat, z_m1_dat, z_addr, z_wdat;
   logic        z_m0_ack, z_m0_err, z_m1_ack, z_m1_err;
   logic        z_cyc, z_stb, z_we;
   logic [3:0]  z_sel;

   // Model state: owner -1 = nobody, else master index
   int owner;
   int last;
   int cnt;

   int total = 0;
   int bad   = 0;

   wb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]),
      .m0_addr_i(m_addr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]),
      .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]),
      .m1_addr_i(m_addr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]),
      .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
      .wbs_addr_o(wbs_addr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
      .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err)
   );

   wb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut_nowd (
      .clk_i(clk), .rst_n_i(rst_n),
      .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]),
      .m0_addr_i(m_addr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]),
      .m0_dat_o(z_m0_dat), .m0_ack_o(z_m0_ack), .m0_err_o(z_m0_err),
      .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]),
      .m1_addr_i(m_addr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]),
      .m1_dat_o(z_m1_dat), .m1_ack_o(z_m1_ack), .m1_err_o(z_m1_err),
      .wbs_cyc_o(z_cyc), .wbs_stb_o(z_stb), .wbs_we_o(z_we),
      .wbs_addr_o(z_addr), .wbs_dat_o(z_wdat), .wbs_sel_o(z_sel),
      .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Forced error: this cycle would be the TO-th consecutive unanswered strobe
   function automatic bit exp_expire();
      logic ow;
      if (owner < 0) return 1'b0;
      ow = owner[0];
      return (TO > 0) && m_stb[ow] && !s_ack && !s_err && (cnt + 1 == TO);
   endfunction

   task automatic check_all(input string tag);
      bit          xp;
      logic        ow;
      logic        e_cyc, e_stb, e_raw, e_we;
      logic [31:0] e_addr, e_dat;
      logic [3:0]  e_sel;
      xp = exp_expire();
      ow = owner[0];
      e_cyc = 1'b0; e_stb = 1'b0; e_raw = 1'b0; e_we = 1'b0;
      e_addr = '0; e_dat = '0; e_sel = '0;
      if (owner >= 0) begin
         e_cyc  = m_cyc[ow];
         e_raw  = m_stb[ow];
         e_stb  = m_stb[ow] & ~xp;
         e_we   = m_we[ow];
         e_addr = m_addr[ow];
         e_dat  = m_dat[ow];
         e_sel  = m_sel[ow];
      end
      chk1 ({tag, ".wbs_cyc"},  wbs_cyc_o,  e_cyc);
      chk1 ({tag, ".wbs_stb"},  wbs_stb_o,  e_stb);
      chk1 ({tag, ".wbs_we"},   wbs_we_o,   e_we);
      chk32({tag, ".wbs_addr"}, wbs_addr_o, e_addr);
      chk32({tag, ".wbs_dat"},  wbs_dat_o,  e_dat);
      chk32({tag, ".wbs_sel"},  32'(wbs_sel_o), 32'(e_sel));
      chk1 ({tag, ".m0_ack"},   m0_ack_o, (owner == 0) ? s_ack : 1'b0);
      chk1 ({tag, ".m0_err"},   m0_err_o, (owner == 0) ? (s_err | xp) : 1'b0);
      chk32({tag, ".m0_dat"},   m0_dat_o, (owner == 0) ? s_dat : 32'h0);
      chk1 ({tag, ".m1_ack"},   m1_ack_o, (owner == 1) ? s_ack : 1'b0);
      chk1 ({tag, ".m1_err"},   m1_err_o, (owner == 1) ? (s_err | xp) : 1'b0);
      chk32({tag, ".m1_dat"},   m1_dat_o, (owner == 1) ? s_dat : 32'h0);
      chk1 ({tag, ".nowd_stb"},    z_stb,    e_raw);
      chk1 ({tag, ".nowd_m0_err"}, z_m0_err, (owner == 0) ? s_err : 1'b0);
      chk1 ({tag, ".nowd_m1_err"}, z_m1_err, (owner == 1) ? s_err : 1'b0);
   endtask

   // Check the current cycle, then advance the model across one clock edge
   task automatic tick(input string tag);
      int   no, nl, nc;
      bit   xp, busy;
      logic ow;
      #1;
      check_all(tag);
      xp   = exp_expire();
      ow   = owner[0];
      busy = (owner >= 0) && m_cyc[ow];
      nc   = (busy && m_stb[ow] && !s_ack && !s_err && !xp) ? cnt + 1 : 0;
      no   = owner;
      nl   = last;
      if (!busy) begin
         if (m_cyc[0] && m_cyc[1]) no = 1 - last;
         else if (m_cyc[0])        no = 0;
         else if (m_cyc[1])        no = 1;
         else                      no = -1;
         if (no >= 0) nl = no;
      end
      @(posedge clk);
      owner = no;
      last  = nl;
      cnt   = nc;
      #1;
   endtask

   // Wait (bounded) for master m to own a strobing bus, ack it once, release
   task automatic xfer(input int m, input bit rearm, input string tag, output int waited);
      logic mi;
      mi = m[0];
      waited = 0;
      #1;
      while (!(wbs_cyc_o && wbs_stb_o) && waited < 6) begin
         tick({tag, ".wait"});
         waited++;
      end
      chk1 ({tag, ".granted"}, wbs_cyc_o & wbs_stb_o, 1'b1);
      chk32({tag, ".addr"}, wbs_addr_o, (m == 1) ? A1 : A0);
      s_ack = 1'b1;
      s_dat = $urandom;
      tick({tag, ".ack"});
      s_ack = 1'b0;
      m_cyc[mi] = 1'b0;
      m_stb[mi] = 1'b0;
      tick({tag, ".drop"});
      if (rearm) begin
         m_cyc[mi] = 1'b1;
         m_stb[mi] = 1'b1;
      end
   endtask

   initial begin
      int w;
      owner = -1; last = 0; cnt = 0;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
         m_dat[i] = 32'h1111_0000 * (i + 1); m_sel[i] = 4'hF;
      end
      m_addr[0] = A0; m_addr[1] = A1;
      s_dat = '0; s_ack = 1'b0; s_err = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      chk1("reset.wbs_cyc_const", wbs_cyc_o, 1'b0);
      rst_n = 1'b1;
      tick("post_reset");

      // M0 single read at 0x100, slave answers after 2 wait cycles
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0] = 32'h100;
      tick("rd.req");
      tick("rd.w1");
      tick("rd.w2");
      s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
      #1;
      chk32("rd.m0_dat_const", m0_dat_o, 32'hDEAD_BEEF);
      chk1 ("rd.m0_ack_const", m0_ack_o, 1'b1);
      chk1 ("rd.m1_ack_const", m1_ack_o, 1'b0);
      chk32("rd.addr_const", wbs_addr_o, 32'h100);
      tick("rd.ack");
      s_ack = 1'b0; s_dat = '0;
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_addr[0] = A0;
      tick("rd.done");
      chk1("rd.ack_one_cycle", m0_ack_o, 1'b0);
      tick("rd.idle");

      // Simultaneous requests: M1 first, then direct handover to M0
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
      tick("tie.req");
      xfer(1, 1'b0, "tie.m1", w);
      chk32("tie.m1_no_wait", 32'(w), 32'd0);
      xfer(0, 1'b0, "tie.m0", w);
      chk32("tie.handover_no_idle", 32'(w), 32'd0);
      tick("tie.idle");

      // Six back-to-back transactions alternate M1, M0, M1, M0, M1, M0
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
      tick("alt.req");
      for (int t = 0; t < 6; t++) begin
         xfer((t % 2 == 0) ? 1 : 0, 1'b1, $sformatf("alt%0d", t), w);
      end
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
      m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
      tick("alt.drain");
      tick("alt.idle");

      // M1 read-modify-write over 3 strobes; M0 waits for the CYC to end
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
      tick("rmw.req");
      for (int p = 0; p < 3; p++) begin
         m_stb[1] = 1'b1; s_ack = 1'b1; s_dat = $urandom;
         #1;
         chk32($sformatf("rmw%0d.addr_const", p), wbs_addr_o, A1);
         chk1 ($sformatf("rmw%0d.m0_ack_const", p), m0_ack_o, 1'b0);
         tick($sformatf("rmw%0d.ack", p));
         s_ack = 1'b0; m_stb[1] = 1'b0;
         if (p == 0) begin
            m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
         end
         tick($sformatf("rmw%0d.gap", p));
      end
      m_cyc[1] = 1'b0;
      tick("rmw.release");
      xfer(0, 1'b0, "rmw.m0", w);
      chk32("rmw.m0_next_edge", 32'(w), 32'd0);
      tick("rmw.idle");

      // Slave never answers: forced error every 8th unanswered strobe
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      tick("wd.req");
      for (int k = 1; k <= 20; k++) begin
         #1;
         chk1($sformatf("wd%0d.m0_err_const", k), m0_err_o, (k % 8 == 0));
         chk1($sformatf("wd%0d.stb_const", k), wbs_stb_o, (k % 8 != 0));
         chk1($sformatf("wd%0d.nowd_err_const", k), z_m0_err, 1'b0);
         tick($sformatf("wd%0d", k));
      end
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
      tick("wd.drop");
      tick("wd.idle");

      // Asynchronous reset while M1 has an outstanding strobe
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
      tick("rst.req");
      tick("rst.own");
      #2;
      rst_n = 1'b0;
      owner = -1; last = 0; cnt = 0;
      #1;
      check_all("rst.async");
      chk1("rst.wbs_cyc_const", wbs_cyc_o, 1'b0);
      chk1("rst.wbs_stb_const", wbs_stb_o, 1'b0);
      m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick("rst.idle");
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
      tick("rst.tie");
      #1;
      chk32("rst.tie_m1_const", wbs_addr_o, A1);
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
      m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
      tick("rst.drop");

      // Random traffic against the model
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(0, 3) == 0) m_cyc[i] = ~m_cyc[i];
            m_stb[i]  = m_cyc[i] & ($urandom_range(0, 3) != 0);
            m_we[i]   = 1'($urandom);
            m_addr[i] = $urandom;
            m_dat[i]  = $urandom;
            m_sel[i]  = 4'($urandom);
         end
         s_ack = ($urandom_range(0, 2) == 0);
         s_err = ($urandom_range(0, 15) == 0);
         s_dat = $urandom;
         tick($sformatf("rnd%0d", c));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
